// File: rtl/cnt5_digits_pkg.sv
// Shared constants and types for the five-digit cascaded counter.
// Used by cnt5_digits and cnt5_digit_cell.
package cnt5_digits_pkg;

  localparam int NUM_DIGITS = 5;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Bits needed to hold values 0..base-1; never less than one bit.
  function automatic int digit_width(input int base);
    return (base <= 2) ? 1 : $clog2(base);
  endfunction

endpackage

// File: rtl/cnt5_digit_cell.sv
// One modulo-BASE up/down digit with synchronous clamped load.
// step_o is the carry (up) or borrow (down) into the next digit.
module cnt5_digit_cell
  import cnt5_digits_pkg::*;
#(
  parameter int BASE = 2,
  parameter int DW   = 1
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          step_i,
  input  logic          hold_i,
  input  dir_e          dir_i,
  input  logic          nload_i,
  input  logic [DW-1:0] loadvalue_i,
  output logic [DW-1:0] digit_o,
  output logic          step_o
);

  localparam logic [DW-1:0] LP_MAX  = DW'(BASE - 1);
  localparam logic [DW:0]   LP_BASE = (DW + 1)'(BASE);

  logic [DW-1:0] r_digit;
  logic          w_at_wrap;
  logic [DW-1:0] w_load;

  assign w_at_wrap = (dir_i == DIR_UP) ? (r_digit == LP_MAX) : (r_digit == '0);
  assign step_o    = step_i & w_at_wrap;
  assign w_load    = ({1'b0, loadvalue_i} >= LP_BASE) ? LP_MAX : loadvalue_i;
  assign digit_o   = r_digit;

  // NOTE: sequential state uses non-blocking assignments so every digit
  // samples the same pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_digit <= '0;
    end else if (!nload_i) begin
      r_digit <= w_load;
    end else if (step_i && !hold_i) begin
      if (dir_i == DIR_UP) r_digit <= w_at_wrap ? '0 : r_digit + DW'(1);
      else                 r_digit <= w_at_wrap ? LP_MAX : r_digit - DW'(1);
    end
  end

endmodule

// File: rtl/cnt5_digits.sv
// Five-digit cascaded modulo-base_p up/down counter with a prescaled LSD.
// Optional saturation instead of wrap-around: define CNT5_DIGITS_SATURATE_EN.
module cnt5_digits
  import cnt5_digits_pkg::*;
#(
  parameter  int base_p    = 2,
  parameter  int stage0_tc = 4,
  localparam int DW        = digit_width(base_p)
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          enable_i,
  input  logic          nload_i,
  input  logic [DW-1:0] loadvalue1_i,
  input  logic [DW-1:0] loadvalue2_i,
  input  logic          up_i,
  output logic [DW-1:0] count0_o,
  output logic [DW-1:0] count1_o,
  output logic [DW-1:0] count2_o,
  output logic [DW-1:0] count3_o,
  output logic [DW-1:0] count4_o
);

  localparam int             PW    = digit_width(stage0_tc + 1);
  localparam logic [PW-1:0]  LP_TC = PW'(stage0_tc);

  logic [PW-1:0]   r_prescale;
  logic            w_tick;
  logic            w_hold;
  dir_e            w_dir;
  logic [DW-1:0]   w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_carry;

  assign w_dir  = up_i ? DIR_UP : DIR_DOWN;
  assign w_tick = enable_i & nload_i & (r_prescale == LP_TC);

  // NOTE: asynchronous active-low reset in the sensitivity list so the
  // counter clears without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_prescale <= '0;
    end else if (!nload_i) begin
      r_prescale <= '0;
    end else if (enable_i) begin
      r_prescale <= (r_prescale == LP_TC) ? '0 : r_prescale + PW'(1);
    end
  end

`ifdef CNT5_DIGITS_SATURATE_EN
  // Carry out of the top digit means every digit sits at its limit: freeze them.
  assign w_hold = w_carry[NUM_DIGITS-1];
`else
  logic w_unused_carry;
  assign w_hold         = 1'b0;
  assign w_unused_carry = w_carry[NUM_DIGITS-1];
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic w_step_in;
    if (i == 0) begin : g_lsd
      assign w_step_in = w_tick;
    end else begin : g_upper
      assign w_step_in = w_carry[i-1];
    end

    cnt5_digit_cell #(
      .BASE(base_p),
      .DW  (DW)
    ) u_cell (
      .clk_i      (clk_i),
      .nrst_i     (nrst_i),
      .step_i     (w_step_in),
      .hold_i     (w_hold),
      .dir_i      (w_dir),
      .nload_i    (nload_i),
      .loadvalue_i((i % 2 == 0) ? loadvalue1_i : loadvalue2_i),
      .digit_o    (w_digit[i]),
      .step_o     (w_carry[i])
    );
  end

  assign count0_o = w_digit[0];
  assign count1_o = w_digit[1];
  assign count2_o = w_digit[2];
  assign count3_o = w_digit[3];
  assign count4_o = w_digit[4];

endmodule

// File: tb/tb_cnt5_digits.sv
// Directed bench for cnt5_digits with base_p = 10, stage0_tc = 4.
// Digits are packed count4..count0 into 20 bits, so values read as BCD in hex.
module tb_cnt5_digits;

`ifdef CNT5_DIGITS_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       enable = 1'b0;
  logic       nload = 1'b1;
  logic [3:0] lv1 = '0;
  logic [3:0] lv2 = '0;
  logic       up = 1'b1;
  logic [3:0] c0, c1, c2, c3, c4;

  int n_asserts = 0;
  int n_fail    = 0;

  cnt5_digits #(
    .base_p   (10),
    .stage0_tc(4)
  ) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .enable_i    (enable),
    .nload_i     (nload),
    .loadvalue1_i(lv1),
    .loadvalue2_i(lv2),
    .up_i        (up),
    .count0_o    (c0),
    .count1_o    (c1),
    .count2_o    (c2),
    .count3_o    (c3),
    .count4_o    (c4)
  );

  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {c4, c3, c2, c1, c0};
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset with no clock edge yet.
    #1 nrst = 1'b0;
    #2 check("reset_async_start", 20'h00000);
    enable = 1'b1;
    up     = 1'b1;
    #1 nrst = 1'b1;

    clk_n(4);  check("prescale_4clk_no_tick", 20'h00000);
    clk_n(1);  check("first_tick_5clk", 20'h00001);
    clk_n(5);  check("second_tick_10clk", 20'h00002);

    clk_n(235); check("count_to_49", 20'h00049);
    clk_n(5);   check("carry_same_edge_50", 20'h00050);

    // Load all nines then one tick up.
    lv1 = 4'd9; lv2 = 4'd9; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("load_all_9", 20'h99999);
    clk_n(4);  check("all_9_before_tick", 20'h99999);
    clk_n(1);  check("full_wrap_up", SAT ? 20'h99999 : 20'h00000);

    // Load with enable high; prescaler restarts from 0.
    lv1 = 4'd3; lv2 = 4'd7; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("load_3_7", 20'h37373);
    clk_n(4);  check("after_load_4clk", 20'h37373);
    clk_n(1);  check("after_load_tick", 20'h37374);

    // Out-of-range load values clamp to base_p-1.
    lv1 = 4'd12; lv2 = 4'd0; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("clamp_even_12", 20'h90909);
    lv1 = 4'd0; lv2 = 4'd15; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("clamp_odd_15", 20'h09090);

    // Asynchronous reset between edges, mid-prescale.
    clk_n(2);
    nrst = 1'b0;
    #2 check("reset_mid_count", 20'h00000);
    up = 1'b0;
    #2 nrst = 1'b1;
    clk_n(4);  check("down_before_tick", 20'h00000);
    clk_n(1);  check("full_wrap_down", SAT ? 20'h00000 : 20'h99999);
    clk_n(5);  check("down_second_tick", SAT ? 20'h00000 : 20'h99998);

    // Direction change mid-prescale keeps the phase.
    lv1 = 4'd5; lv2 = 4'd5; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("load_5", 20'h55555);
    clk_n(2);  check("down_phase_2", 20'h55555);
    up = 1'b1;
    clk_n(3);  check("dir_change_tick_up", 20'h55556);

    // Enable low freezes prescaler phase and digits.
    clk_n(2);  check("phase_2_before_hold", 20'h55556);
    enable = 1'b0;
    clk_n(7);  check("hold_7clk", 20'h55556);
    enable = 1'b1;
    clk_n(2);  check("resume_2clk", 20'h55556);
    clk_n(1);  check("resume_tick_3clk", 20'h55557);

    // Load takes priority with enable low.
    enable = 1'b0; lv1 = 4'd1; lv2 = 4'd2; nload = 1'b0;
    clk_n(1); nload = 1'b1;
    check("load_enable_low", 20'h12121);
    clk_n(10); check("hold_after_load", 20'h12121);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
